seg_display_arbiter: RTL and testbench

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_display_arbiter.sv | 171 +++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - two-requester arbiter driving a multiplexed 4-digit 7-segment display
module seg_display_arbiter #(
    parameter int PRESCALE     = 16384,
    parameter int BLANK        = 64,
    parameter int DWELL_FRAMES = 8
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Req_A,
    input  logic [15:0] i_Data_A,
    input  logic        i_Req_B,
    input  logic [15:0] i_Data_B,
    output logic        o_Gnt_A,
    output logic        o_Gnt_B,
    output logic        o_Busy,
    output logic [3:0]  drains,
    output logic [7:0]  leds
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    localparam logic [15:0] SLOT_LAST  = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    localparam logic [7:0]  DWELL_MIN  = 8'(DWELL_FRAMES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] snap_q, snap_d;
    logic        last_b_q, last_b_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;

    logic [7:0]  dwell_inc;
    logic        own_req, oth_req, pick_b;
    logic [15:0] own_data, oth_data;
    logic [3:0]  nibble;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            digit_q  <= 2'd0;
            dwell_q  <= 8'd0;
            snap_q   <= 16'd0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            dwell_q  <= dwell_d;
            snap_q   <= snap_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        dwell_d  = dwell_q;
        snap_d   = snap_q;
        last_b_d = last_b_q;
        gnt_a_d  = gnt_a_q;
        gnt_b_d  = gnt_b_q;

        dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        own_req   = gnt_b_q ? i_Req_B  : i_Req_A;
        oth_req   = gnt_b_q ? i_Req_A  : i_Req_B;
        own_data  = gnt_b_q ? i_Data_B : i_Data_A;
        oth_data  = gnt_b_q ? i_Data_A : i_Data_B;
        // B wins a tie only when A was the most recent owner
        pick_b    = i_Req_B && (!i_Req_A || !last_b_q);

        case (state_q)
            S_IDLE: begin
                cnt_d   = 16'd0;
                digit_d = 2'd0;
                if (i_Req_A || i_Req_B) begin
                    gnt_a_d  = !pick_b;
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    snap_d   = pick_b ? i_Data_B : i_Data_A;
                    dwell_d  = 8'd0;
                    state_d  = S_BLANK;
                end
            end
            S_BLANK: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cnt_q != SLOT_LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d   = 16'd0;
                    digit_d = digit_q + 2'd1;
                    state_d = S_BLANK;
                    if (digit_q == 2'd3) begin
                        dwell_d = dwell_inc;
                        if (!own_req && !oth_req) begin
                            state_d = S_IDLE;
                            gnt_a_d = 1'b0;
                            gnt_b_d = 1'b0;
                        end else if (oth_req && (!own_req || dwell_inc >= DWELL_MIN)) begin
                            gnt_a_d  = gnt_b_q;
                            gnt_b_d  = gnt_a_q;
                            last_b_d = gnt_a_q;
                            snap_d   = oth_data;
                            dwell_d  = 8'd0;
                        end else begin
                            snap_d = own_data;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_a_d = 1'b0;
                gnt_b_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        drains = 4'd0;
        leds   = 8'd0;
        nibble = snap_q[{digit_q, 2'b00} +: 4];
        if (state_q == S_SHOW) begin
            drains = 4'b0001 << digit_q;
            leds   = {(digit_q == 2'd0) && gnt_b_q, seg7(nibble)};
        end
    end

    assign o_Gnt_A = gnt_a_q;
    assign o_Gnt_B = gnt_b_q;
    assign o_Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed self-checking bench for seg_display_arbiter
module tb_seg_display_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_a, req_b;
    logic [15:0] data_a, data_b;
    logic        gnt_a, gnt_b, busy;
    logic [3:0]  drains;
    logic [7:0]  leds;

    int total;
    int bad;

    seg_display_arbiter #(
        .PRESCALE    (8),
        .BLANK       (2),
        .DWELL_FRAMES(2)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Req_A (req_a),
        .i_Data_A(data_a),
        .i_Req_B (req_b),
        .i_Data_B(data_b),
        .o_Gnt_A (gnt_a),
        .o_Gnt_B (gnt_b),
        .o_Busy  (busy),
        .drains  (drains),
        .leds    (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 16'h0000;
        data_b = 16'h0000;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 16'hFFFF;
        data_b = 16'hFFFF;
        step(2);
        total++;
        if ({gnt_a, gnt_b, busy, drains, leds} !== 15'd0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b%b busy=%b drains=%b leds=%h want all 0",
                     gnt_a, gnt_b, busy, drains, leds);
        end
    endtask

    task automatic test_scan();
        logic [7:0] tbl [4] = '{8'h71, 8'h6F, 8'h77, 8'h06};
        logic [3:0] exp_dr;
        logic [7:0] exp_ld;
        int slot, pos;
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h1A9F;
        step(1);
        total++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL scan_grant got gnt=%b%b busy=%b want 101", gnt_a, gnt_b, busy);
        end
        for (int k = 0; k < 64; k++) begin
            slot   = (k % 32) / 8;
            pos    = k % 8;
            exp_dr = (pos < 2) ? 4'd0 : (4'b0001 << slot);
            exp_ld = (pos < 2) ? 8'd0 : tbl[slot];
            total++;
            if (drains !== exp_dr || leds !== exp_ld) begin
                bad++;
                $display("FAIL scan_cycle%0d got drains=%b leds=%h want drains=%b leds=%h",
                         k, drains, leds, exp_dr, exp_ld);
            end
            step(1);
        end
    endtask

    task automatic test_tie_break();
        do_reset();
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 16'h0000;
        data_b = 16'h1A9F;
        step(1);
        total++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
            bad++;
            $display("FAIL tie_a_wins got gnt=%b%b want 10", gnt_a, gnt_b);
        end
        req_a = 1'b0;
        step(31);
        total++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
            bad++;
            $display("FAIL tie_hold_frame got gnt=%b%b want 10", gnt_a, gnt_b);
        end
        step(1);
        total++;
        if (gnt_a !== 1'b0 || gnt_b !== 1'b1) begin
            bad++;
            $display("FAIL tie_switch_b got gnt=%b%b want 01", gnt_a, gnt_b);
        end
        step(2);
        total++;
        if (drains !== 4'b0001 || leds !== 8'hF1) begin
            bad++;
            $display("FAIL tie_b_dp got drains=%b leds=%h want 0001 f1", drains, leds);
        end
        step(8);
        total++;
        if (drains !== 4'b0010 || leds !== 8'h6F) begin
            bad++;
            $display("FAIL tie_b_digit1 got drains=%b leds=%h want 0010 6f", drains, leds);
        end
    endtask

    task automatic test_dwell();
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h1111;
        data_b = 16'h2222;
        step(1);
        for (int k = 1; k <= 64; k++) begin
            if (k == 5) req_b = 1'b1;
            step(1);
            total++;
            if (gnt_a !== (k < 64) || gnt_b !== (k >= 64)) begin
                bad++;
                $display("FAIL dwell_cycle%0d got gnt=%b%b want %b%b",
                         k, gnt_a, gnt_b, (k < 64), (k >= 64));
            end
        end
        step(2);
        total++;
        if (drains !== 4'b0001 || leds !== 8'hDB) begin
            bad++;
            $display("FAIL dwell_b_show got drains=%b leds=%h want 0001 db", drains, leds);
        end
    endtask

    task automatic test_snapshot();
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h0000;
        step(1);
        step(10);
        data_a = 16'hFFFF;
        total++;
        if (drains !== 4'b0010 || leds !== 8'h3F) begin
            bad++;
            $display("FAIL snap_digit1 got drains=%b leds=%h want 0010 3f", drains, leds);
        end
        step(8);
        total++;
        if (drains !== 4'b0100 || leds !== 8'h3F) begin
            bad++;
            $display("FAIL snap_digit2 got drains=%b leds=%h want 0100 3f", drains, leds);
        end
        step(8);
        total++;
        if (drains !== 4'b1000 || leds !== 8'h3F) begin
            bad++;
            $display("FAIL snap_digit3 got drains=%b leds=%h want 1000 3f", drains, leds);
        end
        step(8);
        total++;
        if (drains !== 4'b0001 || leds !== 8'h71) begin
            bad++;
            $display("FAIL snap_next_d0 got drains=%b leds=%h want 0001 71", drains, leds);
        end
        step(24);
        total++;
        if (drains !== 4'b1000 || leds !== 8'h71) begin
            bad++;
            $display("FAIL snap_next_d3 got drains=%b leds=%h want 1000 71", drains, leds);
        end
    endtask

    task automatic test_release();
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h1234;
        step(1);
        step(3);
        req_a = 1'b0;
        step(28);
        total++;
        if (busy !== 1'b1 || gnt_a !== 1'b1 || drains !== 4'b1000 || leds !== 8'h06) begin
            bad++;
            $display("FAIL release_last_cycle got busy=%b gnt_a=%b drains=%b leds=%h want 1 1 1000 06",
                     busy, gnt_a, drains, leds);
        end
        step(1);
        total++;
        if (busy !== 1'b0 || gnt_a !== 1'b0 || gnt_b !== 1'b0 || drains !== 4'd0 || leds !== 8'd0) begin
            bad++;
            $display("FAIL release_idle got busy=%b gnt=%b%b drains=%b leds=%h want idle zeros",
                     busy, gnt_a, gnt_b, drains, leds);
        end
        step(5);
        total++;
        if (busy !== 1'b0 || gnt_a !== 1'b0) begin
            bad++;
            $display("FAIL release_stays_idle got busy=%b gnt_a=%b want 0 0", busy, gnt_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_a  = 1'b1;
        data_a = 16'h1A9F;
        step(1);
        step(4);
        total++;
        if (drains !== 4'b0001 || leds !== 8'h71) begin
            bad++;
            $display("FAIL midrst_pre got drains=%b leds=%h want 0001 71", drains, leds);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (drains !== 4'd0 || leds !== 8'd0 || gnt_a !== 1'b0 || gnt_b !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async got drains=%b leds=%h gnt=%b%b busy=%b want zeros",
                     drains, leds, gnt_a, gnt_b, busy);
        end
        step(1);
        rst_n = 1'b1;
        total++;
        if (gnt_a !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_release got gnt_a=%b busy=%b want 0 0", gnt_a, busy);
        end
        step(1);
        total++;
        if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_regrant got gnt=%b%b busy=%b want 10 1", gnt_a, gnt_b, busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        data_a = 16'h0000;
        data_b = 16'h0000;
        test_reset();
        test_scan();
        test_tie_break();
        test_dwell();
        test_snapshot();
        test_release();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
